// File: rtl/plu_pkg.sv
// Shared types and helpers for the programmable logic unit.
package plu_pkg;

  localparam int N_IN_MAX = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } plu_state_t;

  function automatic int tw(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/prog_logic_unit_if.sv
// Evaluation request/result handshake for prog_logic_unit.
interface prog_logic_unit_if #(
  parameter int N_IN = 4
) ();

  logic            in_valid;
  logic [N_IN-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_f;
  logic            out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_f
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_f
  );

endinterface

// File: rtl/plu_cfg_loader.sv
// Serial truth-table loader: EMPTY/LOAD/RUN FSM, write pointer and table register.
// Optional PLU_MINTERM_CNT_EN keeps a running count of 1 entries in the table.
module plu_cfg_loader
  import plu_pkg::*;
#(
  parameter int                    N_IN        = 4,
  parameter logic [tw(N_IN)-1:0]   RESET_TABLE = '0,
  parameter bit                    START_RUN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_bit_valid,
  input  logic                  load_bit,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [tw(N_IN)-1:0]   tbl,
  output plu_state_t            state
`ifdef PLU_MINTERM_CNT_EN
  ,
  output logic [N_IN:0]         minterm_cnt
`endif
);

  localparam int              TW       = tw(N_IN);
  localparam logic [N_IN-1:0] CNT_LAST = '1;

  plu_state_t      next_state;
  logic [N_IN-1:0] cnt;
  logic            wr_en;
  logic            last_bit;

  // A bit arriving together with load_start belongs to no sequence and is dropped.
  assign wr_en    = (state == LOAD) && load_bit_valid && !load_start;
  assign last_bit = wr_en && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START_RUN ? RUN : EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY:   if (load_start) next_state = LOAD;
      LOAD:    if (last_bit)   next_state = RUN;
      RUN:     if (load_start) next_state = LOAD;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    load_busy = (state == LOAD);
  end

  // Pointer wraps to 0 naturally after the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tbl       <= RESET_TABLE;
      load_done <= 1'b0;
    end else begin
      load_done <= last_bit;
      if (load_start) begin
        cnt <= '0;
      end else if (wr_en) begin
        cnt      <= cnt + 1'b1;
        tbl[cnt] <= load_bit;
      end
    end
  end

`ifdef PLU_MINTERM_CNT_EN
  function automatic logic [N_IN:0] popcnt(input logic [TW-1:0] v);
    logic [N_IN:0] acc;
    acc = '0;
    for (int i = 0; i < TW; i++) begin
      acc = acc + {{N_IN{1'b0}}, v[i]};
    end
    return acc;
  endfunction

  localparam logic [N_IN:0] RESET_POP = popcnt(RESET_TABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minterm_cnt <= RESET_POP;
    end else if (wr_en && (load_bit != tbl[cnt])) begin
      minterm_cnt <= load_bit ? minterm_cnt + 1'b1 : minterm_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: rtl/prog_logic_unit.sv
// Run-time programmable N_IN-input Boolean function with registered, handshaked result.
// Define PLU_MINTERM_CNT_EN to expose minterm_cnt (number of 1 entries in the table).
module prog_logic_unit
  import plu_pkg::*;
#(
  parameter int                    N_IN        = 4,
  parameter logic [tw(N_IN)-1:0]   RESET_TABLE = '0,
  parameter bit                    START_RUN   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_bit_valid,
  input  logic              load_bit,
  output logic              load_busy,
  output logic              load_done,
  prog_logic_unit_if.slave  io
`ifdef PLU_MINTERM_CNT_EN
  ,
  output logic [N_IN:0]     minterm_cnt
`endif
);

  plu_state_t          state;
  logic [tw(N_IN)-1:0] tbl;
  logic                accept;
  logic                out_valid_q;
  logic                out_f_q;

  plu_cfg_loader #(
    .N_IN        (N_IN),
    .RESET_TABLE (RESET_TABLE),
    .START_RUN   (START_RUN)
  ) u_loader (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .load_bit_valid (load_bit_valid),
    .load_bit       (load_bit),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .tbl            (tbl),
    .state          (state)
`ifdef PLU_MINTERM_CNT_EN
    ,
    .minterm_cnt    (minterm_cnt)
`endif
  );

  // A request coinciding with load_start is still served from the old table,
  // because table writes only start once the FSM is in LOAD.
  assign io.in_ready = (state == RUN) && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_f_q     <= tbl[io.in_data];
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_f     = out_f_q;

endmodule

// File: doc/prog_logic_unit.md
Name: prog_logic_unit

Overview:
- Run-time programmable N-input Boolean function unit.
- Holds a 2^N_IN-entry truth table that is loaded serially, then evaluates input vectors against it.
- Result is registered, with valid/ready on both sides.
- Generalises fixed SOP/POS gate exercises: any function of N_IN variables can be set at run time without resynthesis.

Parameters:
- N_IN, 4, number of function inputs (1..8); table width TW = 2**N_IN.
- RESET_TABLE, {TW{1'b0}}, truth table contents after reset.
- START_RUN, 0, if 1, the unit leaves reset in RUN using RESET_TABLE; if 0, it leaves reset in EMPTY.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: begin (or restart) a table load.
- load_bit_valid  in  1  load_bit is valid this cycle.
- load_bit  in  1  serial table bit, entry 0 first.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when the last bit is written.
- in_valid  in  1  evaluation request.
- in_data  in  N_IN  input vector (minterm index).
- in_ready  out  1  request accepted when in_valid & in_ready.
- out_valid  out  1  result valid.
- out_f  out  1  function value.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async assert, sync release):
  - state = RUN if START_RUN, else EMPTY.
  - table = RESET_TABLE; cnt = 0.
  - load_busy, load_done, out_valid, out_f = 0.
- FSM states: EMPTY, LOAD, RUN.
  - EMPTY -> LOAD on load_start.
  - LOAD -> RUN after the TW-th accepted bit.
  - RUN -> LOAD on load_start.
  - load_start in LOAD restarts: cnt = 0; bits already written stay in the table but are overwritten by the new sequence.
- LOAD:
  - Each cycle with load_bit_valid: table[cnt] <= load_bit; cnt++.
  - load_bit_valid in the same cycle as load_start is ignored; the first bit is accepted on the following cycle.
  - When cnt == TW-1 and load_bit_valid: load_done = 1 next cycle, state = RUN, cnt = 0.
  - load_bit_valid outside LOAD is ignored.
- in_ready = (state == RUN) & (!out_valid | out_ready). It is 0 in EMPTY and LOAD.
- Evaluation, latency 1:
  - On in_valid & in_ready: next cycle out_valid = 1 and out_f = table[in_data].
  - Throughput is 1 per cycle when out_ready is held high.
- Output hold: while out_valid & !out_ready, out_f and out_valid stay stable.
- A result pending when load_start arrives stays valid until accepted; it reflects the table in effect at its evaluation.
- out_valid drops the cycle after the handshake unless a new request is accepted in that same cycle.
- Simultaneous load_start and in_valid in RUN: the request is accepted (in_ready is still 1 that cycle) using the old table; state -> LOAD next cycle.
- Reset mid-load: table returns to RESET_TABLE and the partial load is discarded.

Optional Feature:
- Macro: PLU_MINTERM_CNT_EN.
- With it: extra output minterm_cnt [N_IN:0] gives the number of 1 entries in the table.
  - Reset value = popcount(RESET_TABLE).
  - Maintained incrementally during LOAD: +1 when 1 overwrites 0, -1 when 0 overwrites 1.
  - Always exact on the cycle load_done is high and thereafter.
- Without it: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package plu_pkg: state enum plu_state_t {EMPTY, LOAD, RUN}; function tw(n) = 2**n; localparam N_IN_MAX = 8.
- Sub-module plu_cfg_loader: contains the FSM, cnt, table register and optional minterm counter. It outputs table[TW-1:0] and state.
- The top contains the in/out handshake and the output register.

Test Plan:
- Reset with START_RUN=0 -> in_ready=0, out_valid=0, load_busy=0; in_valid=1 for 5 cycles -> nothing is accepted.
- Load 16'h00F0 (N_IN=4, LSB first, 16 bits):
  - load_done pulses once.
  - Then in_data=4 -> out_f=1 one cycle later; in_data=8 -> out_f=0; in_data=7 -> 1.
- Back-to-back in_data 0..15 with out_ready=1 -> 16 consecutive results equal to bits of 16'h00F0, no bubbles.
- out_ready=0 after in_data=5 is accepted -> out_valid=1 and out_f=1 held, in_ready=0; release -> next request accepted.
- load_start after 7 bits of a load, then 16 bits of 16'hFFFF -> load_done once at the end; every evaluation returns 1; minterm_cnt=16 (with PLU_MINTERM_CNT_EN).
- rst_n asserted mid-load, then released -> state EMPTY, out_valid=0, minterm_cnt=0 with RESET_TABLE=0.
